// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared FSM encodings and timing defaults for the traffic-light phase logic
// Contents:
//   ST_IDLE/ST_RUN/ST_HOLD/ST_DONE  phase_timer state encodings
//   DEFAULT_N, DEFAULT_TOL, DEFAULT_W  default divider half-period, tolerance, countdown width
//   is_busy()                        true while a countdown is active (RUN or HOLD)
package traffic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int DEFAULT_N   = 50000000;
    localparam int DEFAULT_TOL = 2;
    localparam int DEFAULT_W   = 8;

    function automatic logic is_busy(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// rtl/tick_edge_detect.sv - synchronise the slow clock level and emit a 1-cycle tick per rising edge
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   slow_in  in   divided clock level (asynchronous to clk in general)
//   tick     out  registered 1-cycle pulse, high the cycle after the third clk edge seeing slow_in high
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic slow_in,
    output logic tick
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= slow_in;
            s2   <= s1;
            prev <= s2;
            tick <= s2 & ~prev;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - slow-tick countdown for traffic-light phases with a slow-clock period watchdog
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   slow_in    in   divided clock level from the clock divider
//   load       in   1-cycle strobe: load countdown with load_val (highest priority)
//   load_val   in   phase duration in ticks
//   hold       in   freeze countdown while high
//   tick       out  1-cycle pulse per slow_in rising edge
//   remaining  out  current countdown value
//   expire     out  1-cycle pulse when the countdown reaches 0
//   busy       out  high in RUN or HOLD
//   fault      out  sticky slow-clock period violation
module phase_timer
    import traffic_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int TOL = DEFAULT_TOL,
    parameter int W   = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         slow_in,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         tick,
    output logic [W-1:0] remaining,
    output logic         expire,
    output logic         busy,
    output logic         fault
);

    // Counter value seen at a tick: nominal period 2N gives 2N-1 here.
    localparam logic [31:0] LATE_LIMIT  = 32'(2 * N + TOL);
    localparam logic [31:0] EARLY_LIMIT = 32'(2 * N - TOL - 1);
    localparam logic [W-1:0] ONE        = W'(1);

    logic [1:0]  state;
    logic [31:0] period_cnt;
    logic        armed;

    tick_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .slow_in (slow_in),
        .tick    (tick)
    );

    assign busy = is_busy(state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (load) begin
                remaining <= load_val;
                if (load_val != '0) begin
                    state <= ST_RUN;
                end else begin
                    state  <= ST_DONE;
                    expire <= 1'b1;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        // hold takes effect before a coincident tick can decrement
                        if (hold) begin
                            state <= ST_HOLD;
                        end else if (tick) begin
                            if (remaining == ONE) begin
                                remaining <= '0;
                                expire    <= 1'b1;
                                state     <= ST_DONE;
                            end else if (remaining != '0) begin
                                remaining <= remaining - ONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!hold) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    // The first tick after reset only arms; later ticks are checked against the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= '0;
            armed      <= 1'b0;
            fault      <= 1'b0;
        end else if (tick) begin
            period_cnt <= '0;
            armed      <= 1'b1;
            if (armed && (period_cnt < EARLY_LIMIT)) begin
                fault <= 1'b1;
            end
        end else begin
            if (period_cnt != 32'hFFFF_FFFF) begin
                period_cnt <= period_cnt + 32'd1;
            end
            if (armed && (period_cnt >= LATE_LIMIT)) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - self-checking bench for phase_timer (N=4, TOL=1, W=8)
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       slow_in;
    logic       load;
    logic [7:0] load_val;
    logic       hold;
    logic       tick;
    logic [7:0] remaining;
    logic       expire;
    logic       busy;
    logic       fault;

    phase_timer #(.N(4), .TOL(1), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .slow_in   (slow_in),
        .load      (load),
        .load_val  (load_val),
        .hold      (hold),
        .tick      (tick),
        .remaining (remaining),
        .expire    (expire),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [7:0] load_val;
        logic       hold;
        int         ticks;
        logic [7:0] exp_rem;
        logic       exp_busy;
        logic       exp_expire;
    } vec_t;

    typedef struct {
        logic [7:0] rem;
        logic       busy;
        logic       expire;
        logic       fault;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    exp_t e;

    int   vec_count = 0;
    int   miscompares = 0;
    logic slow_en = 1'b0;
    int   sc = 0;
    logic expire_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; slow_in generator (toggle every 4 clk when enabled) advances here.
    task automatic step();
        @(negedge clk);
        if (slow_en) begin
            sc++;
            if (sc == 4) begin
                sc = 0;
                slow_in = ~slow_in;
            end
        end
        if (expire) expire_seen = 1'b1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 20);
        if (!tick) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int gap;
        vecs[0] = '{1'b1, 8'd3, 1'b0, 0, 8'd3, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'd0, 1'b0, 1, 8'd2, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'd0, 1'b0, 1, 8'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'd0, 1'b0, 1, 8'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'd0, 1'b0, 2, 8'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'd5, 1'b1, 2, 8'd5, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'd0, 1'b0, 1, 8'd4, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'd0, 1'b0, 3, 8'd1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'd0, 1'b0, 0, 8'd0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 8'd2, 1'b0, 1, 8'd1, 1'b1, 1'b0};

        rst = 1'b1; slow_in = 1'b0; load = 1'b0; load_val = 8'd0; hold = 1'b0;
        repeat (3) step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_expire", 32'(expire), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // tick latency: high only in the cycle after the third edge sampling slow_in=1
        slow_in = 1'b1;
        step(); chk("lat_e0", 32'(tick), 32'd0);
        step(); chk("lat_e1", 32'(tick), 32'd0);
        step(); chk("lat_e2", 32'(tick), 32'd1);
        step(); chk("lat_e3", 32'(tick), 32'd0);
        slow_in = 1'b0; sc = 0; slow_en = 1'b1;

        wait_tick();
        gap = 0;
        do begin
            step();
            gap++;
        end while (!tick && gap < 20);
        chk("tick_spacing", 32'(gap), 32'd8);
        chk("fault_nominal", 32'(fault), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            load = vecs[i].load; load_val = vecs[i].load_val; hold = vecs[i].hold;
            expire_seen = 1'b0;
            sb.push_back('{vecs[i].exp_rem, vecs[i].exp_busy, vecs[i].exp_expire, 1'b0});
            step();
            load = 1'b0;
            for (int t = 0; t < vecs[i].ticks; t++) wait_tick();
            if (vecs[i].ticks > 0) step();
            e = sb.pop_front();
            chk($sformatf("v%0d_remaining", i), 32'(remaining), 32'(e.rem));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(e.busy));
            chk($sformatf("v%0d_expire", i), 32'(expire_seen), 32'(e.expire));
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'(e.fault));
        end

        // load coinciding with the final tick: load wins, no expire
        wait_tick();
        load = 1'b1; load_val = 8'd7; expire_seen = 1'b0;
        step();
        load = 1'b0;
        chk("coll_remaining", 32'(remaining), 32'd7);
        chk("coll_busy", 32'(busy), 32'd1);
        step();
        chk("coll_no_expire", 32'(expire_seen), 32'd0);
        wait_tick(); step();
        chk("coll_next_dec", 32'(remaining), 32'd6);

        // slow_in stuck low after an armed tick
        wait_tick();
        slow_en = 1'b0; slow_in = 1'b0;
        repeat (10) step();
        chk("stuck_not_yet", 32'(fault), 32'd0);
        step();
        chk("stuck_fault", 32'(fault), 32'd1);
        chk("stuck_count_runs", 32'(remaining), 32'd5);
        sc = 0; slow_en = 1'b1;
        wait_tick(); step();
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("run_with_fault", 32'(remaining), 32'd4);

        // reset mid-RUN with a tick in flight
        wait_tick();
        chk("pre_rst_remaining", 32'(remaining), 32'd4);
        rst = 1'b1; slow_en = 1'b0; slow_in = 1'b0;
        step();
        chk("mid_rst_remaining", 32'(remaining), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_expire", 32'(expire), 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) step();

        // early edge: arm, 7-cycle period (allowed), then 6-cycle period (fault)
        slow_in = 1'b1; repeat (3) step();
        slow_in = 1'b0; repeat (4) step();
        slow_in = 1'b1; repeat (3) step();
        slow_in = 1'b0; repeat (3) step();
        chk("period7_ok", 32'(fault), 32'd0);
        slow_in = 1'b1; repeat (3) step();
        slow_in = 1'b0; repeat (4) step();
        chk("period6_fault", 32'(fault), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
